// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared constants, state encoding and the rotating-priority search for rr_mux4_arbiter.
package rr_mux4_arbiter_pkg;

    localparam int unsigned NLANES = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First requesting lane in the order ptr, ptr+1, ptr+2, ptr+3 (mod NLANES).
    function automatic pick_t rr_pick(input logic [NLANES-1:0] req,
                                      input logic [SEL_W-1:0]  ptr);
        pick_t            p;
        logic [SEL_W-1:0] lane;
        p.found = 1'b0;
        p.idx   = ptr;
        for (int unsigned k = 0; k < NLANES; k++) begin
            lane = ptr + SEL_W'(k);
            if (!p.found && req[lane]) begin
                p.found = 1'b1;
                p.idx   = lane;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux4_bus.sv
// W-bit combinational 4:1 lane multiplexer.
module mux4_bus
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [SEL_W-1:0]    sel,
    input  logic [NLANES*W-1:0] d,
    output logic [W-1:0]        lane_c
);

    always_comb begin
        lane_c = d[0 +: W];
        case (sel)
            2'd1:    lane_c = d[W   +: W];
            2'd2:    lane_c = d[2*W +: W];
            2'd3:    lane_c = d[3*W +: W];
            default: lane_c = d[0 +: W];
        endcase
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter with a per-owner hold limit driving a shared 4:1 data mux.
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NLANES-1:0]   req,
    input  logic [NLANES*W-1:0] d,
    output logic [NLANES-1:0]   gnt,
    output logic [SEL_W-1:0]    sel,
    output logic                busy,
    output logic [W-1:0]        y
);

    localparam int unsigned     HOLD_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT = {HOLD_W{1'b1}};
    localparam bit              HOLD_EN  = (MAX_HOLD != 0);

    state_e             state;
    logic [SEL_W-1:0]   ptr;
    logic [HOLD_W-1:0]  hold_cnt;

    logic               release_c;
    logic [SEL_W-1:0]   next_ptr_c;
    pick_t              idle_pick_c;
    pick_t              next_pick_c;
    logic [W-1:0]       lane_c;

    // sel always names the current owner while a grant is active.
    always_comb begin
        release_c   = !req[sel] || (HOLD_EN && (hold_cnt == HOLD_LIM));
        next_ptr_c  = sel + SEL_W'(1);
        idle_pick_c = rr_pick(req, ptr);
        next_pick_c = rr_pick(req, next_ptr_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (idle_pick_c.found) begin
                        state    <= ST_GRANT;
                        gnt      <= NLANES'(1) << idle_pick_c.idx;
                        sel      <= idle_pick_c.idx;
                        busy     <= 1'b1;
                        hold_cnt <= HOLD_W'(1);
                    end
                end
                ST_GRANT: begin
                    if (!release_c) begin
                        if (hold_cnt != HOLD_SAT) begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end else begin
                        // Former owner becomes lowest priority; hand over without a bubble.
                        ptr <= next_ptr_c;
                        if (next_pick_c.found) begin
                            gnt      <= NLANES'(1) << next_pick_c.idx;
                            sel      <= next_pick_c.idx;
                            hold_cnt <= HOLD_W'(1);
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mux4_bus #(.W(W)) u_mux (
        .sel    (sel),
        .d      (d),
        .lane_c (lane_c)
    );

    assign y = lane_c & {W{busy}};

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data multiplexer among four requesters; it computes the mux select and forwards the granted lane's data.
- Sits in front of the lab's 4:1 mux datapath and replaces the free-running select counter used in earlier benches with request-driven sequencing.
- Grants one owner at a time, bounds ownership with a hold limit and rotates priority fairly.

Parameters:
- W, 8, data width of each requester lane and of the output.
- MAX_HOLD, 4, maximum consecutive granted cycles per owner; 0 = unlimited (release only on req drop).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request per lane; req[i] level-held while lane i wants the resource
- d  input  4*W  packed lane data; lane i = d[i*W +: W]
- gnt  output  4  one-hot grant, registered; all-zero when idle
- sel  output  2  registered mux select = index of current owner
- busy  output  1  registered; 1 when any grant is active
- y  output  W  combinational: lane sel of d when busy, else 0

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, gnt=0000, sel=00, busy=0, ptr=0, hold_cnt=0; y=0 as a consequence. rst takes priority over all other events; reset mid-grant drops the grant at that edge.
- Rotating pointer ptr (2 bits) marks the highest-priority lane. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4 (wrap 3->0).
- State IDLE: if req != 0, grant the first requesting lane in search order at the next edge.
  - Grant sets gnt, sel, busy=1, hold_cnt=1 and moves to GRANT; otherwise stay in IDLE.
  - Latency: req sampled at edge k gives gnt valid after edge k (visible in cycle k+1).
- State GRANT, owner o: release condition R = (req[o]==0) OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD).
  - If not R: hold gnt/sel and increment hold_cnt. The counter is sized ceil(log2(MAX_HOLD+1)), minimum 1 bit; it saturates and never wraps.
  - If R: ptr <= o+1 mod 4, then search req from the new ptr.
    - If a lane is found: switch directly to it at this edge (no idle bubble), hold_cnt=1, stay in GRANT.
    - If none: gnt=0000, busy=0, back to IDLE, sel holds its last value.
  - The former owner is lowest priority in the search, so it is re-granted only if no other lane requests.
- Owner drops req at cycle n: gnt changes at the edge ending cycle n; y still shows the owner's data in cycle n.
- Simultaneous requests are resolved purely by ptr order; a new request arriving during a grant waits and never preempts.
- gnt is always one-hot or zero, and sel == index of the set gnt bit whenever busy=1.
- With MAX_HOLD=N and all four lanes requesting continuously, each lane owns exactly N consecutive cycles in order o, o+1, o+2, o+3, repeating.

Decomposition:
- Shared package/include: state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1, plus the lane-count constant NLANES=4.
- One natural sub-module, mux4_bus: W-bit combinational 4:1 mux (inputs sel and d; output lane data), instantiated once; rr_mux4_arbiter ANDs its output with busy.
- The pointer search is a function, not a separate module.

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111 -> gnt=0000, sel=00, busy=0, y=0. Release rst -> gnt=0001 one cycle later, y=d lane 0.
- Hold limit: MAX_HOLD=4, req=1111 held for 20 cycles -> gnt sequence 0001x4, 0010x4, 0100x4, 1000x4, 0001x4, with no idle cycles; sel follows 0,1,2,3,0.
- Early release: lane 2 alone owns; drop req[2] after 2 granted cycles -> next edge gnt=0000, busy=0. Then assert req=1001 -> gnt=1000 (ptr=3 wins over lane 0).
- Wrap/fairness: ptr=3 with req=0001 only -> gnt=0001. With req=0011 after lane 0 releases -> lane 1 granted, not lane 0.
- Sole requester re-grant: MAX_HOLD=2, req=0100 constant -> gnt=0100 continuously with hold_cnt reset to 1 every 2 cycles. busy stays 1 and no bubble appears.
- Reset mid-grant: rst=1 while gnt=0010 and hold_cnt=3 -> next edge all outputs zero, ptr=0. After release with req=0110 -> gnt=0010.
